// File: rtl/uart_pkg.sv
// Shared UART receive definitions: rx state encoding, word-length codes and
// LSR bit positions used by the register block.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK_WAIT
    } rx_state_e;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_PE   = 2;
    localparam int LSR_FE   = 3;
    localparam int LSR_BI   = 4;
    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;
    localparam int LSR_ERR  = 7;

    // Index of the final data bit for a word-length code (5..8 bits).
    function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
        return {1'b0, wls} + 3'd4;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through receive FIFO with flush, occupancy
// count and an overflow strobe for pushes that find it full.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic [6:0]   count_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         overflow_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [6:0]    cnt_q, cnt_d;
    logic          do_push, do_pop, wr_en;

    always_comb begin
        empty_o    = (cnt_q == 7'd0);
        full_o     = (cnt_q == 7'(DEPTH));
        do_pop     = pop_i && !empty_o;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push    = push_i && (!full_o || do_pop);
        overflow_o = push_i && full_o && !do_pop && !clr_i;
        wr_en      = do_push && !clr_i;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + 7'(do_push) - 7'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: 16x oversampling frame decoder, receive FIFO,
// sticky line-status flags and character timeout. Define UART_RX_PARITY_EN to build parity support.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH    = 32,
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        RX_I,
    input  logic [15:0] DIVISOR_I,
    input  logic [1:0]  WLS_I,
    input  logic        PEN_I,
    input  logic        EPS_I,
    input  logic        FIFO_CLR_I,
    input  logic        POP_I,
    input  logic        ERR_CLR_I,
    output logic [7:0]  DATA_O,
    output logic        VALID_O,
    output logic [6:0]  COUNT_O,
    output logic        OE_O,
    output logic        PE_O,
    output logic        FE_O,
    output logic        BI_O,
    output logic        TIMEOUT_O
);

    localparam int              TO_W   = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_TICKS);

    logic            sync1_q, sync2_q, rx_prev_q, rx_s;
    logic [15:0]     div_cnt_q, div_cnt_d, div_last_q, div_eff;
    logic            tick;
    rx_state_e       state_q, state_d;
    logic [3:0]      tick_cnt_q, tick_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_bit_q, par_bit_d;
    logic [1:0]      wls_q, wls_d;
    logic            pen_q, pen_d, eps_q, eps_d, pen_in;
    logic            push_req, pe_set, fe_set, bi_set, mid_bit;
    logic            oe_q, oe_d, pe_q, pe_d, fe_q, fe_d, bi_q, bi_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            fifo_empty, fifo_full, fifo_ovf;

`ifdef UART_RX_PARITY_EN
    assign pen_in = PEN_I;
`else
    logic unused_pen;
    assign pen_in     = 1'b0;
    assign unused_pen = PEN_I;
`endif

    assign rx_s = sync2_q;

    always_comb begin
        div_eff   = (DIVISOR_I == 16'd0) ? 16'd1 : DIVISOR_I;
        tick      = 1'b0;
        div_cnt_d = div_cnt_q + 16'd1;
        if (DIVISOR_I != div_last_q) begin
            div_cnt_d = '0;
        end else if (div_cnt_q >= div_eff - 16'd1) begin
            tick      = 1'b1;
            div_cnt_d = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        wls_d      = wls_q;
        pen_d      = pen_q;
        eps_d      = eps_q;
        push_req   = 1'b0;
        pe_set     = 1'b0;
        fe_set     = 1'b0;
        bi_set     = 1'b0;
        mid_bit    = tick && (tick_cnt_q == 4'd15);
        unique case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d    = RX_START;
                    tick_cnt_d = '0;
                    wls_d      = WLS_I;
                    pen_d      = pen_in;
                    eps_d      = EPS_I;
                end
            end
            RX_START: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        shift_d    = '0;
                        par_bit_d  = 1'b0;
                        state_d    = rx_s ? RX_IDLE : RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (tick) tick_cnt_d = tick_cnt_q + 4'd1;
                if (mid_bit) begin
                    shift_d[bit_cnt_q] = rx_s;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == last_bit_idx(wls_q))
                        state_d = pen_q ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (tick) tick_cnt_d = tick_cnt_q + 4'd1;
                if (mid_bit) begin
                    par_bit_d = rx_s;
                    // Parity error when data^parity disagrees with the selected sense.
                    pe_set    = (((^shift_q) ^ rx_s) == eps_q);
                    state_d   = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick) tick_cnt_d = tick_cnt_q + 4'd1;
                if (mid_bit) begin
                    push_req = 1'b1;
                    state_d  = RX_IDLE;
                    if (!rx_s) begin
                        fe_set = 1'b1;
                        if (shift_q == 8'd0 && !par_bit_q) begin
                            bi_set  = 1'b1;
                            state_d = RX_BREAK_WAIT;
                        end
                    end
                end
            end
            RX_BREAK_WAIT: begin
                if (rx_s) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Sticky flags: a set arriving with the clear takes precedence.
    always_comb begin
        oe_d = (oe_q & ~ERR_CLR_I) | fifo_ovf;
        pe_d = (pe_q & ~ERR_CLR_I) | pe_set;
        fe_d = (fe_q & ~ERR_CLR_I) | fe_set;
        bi_d = (bi_q & ~ERR_CLR_I) | bi_set;
    end

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (FIFO_CLR_I || push_req || POP_I || fifo_empty)
            to_cnt_d = '0;
        else if (tick && to_cnt_q != TO_MAX)
            to_cnt_d = to_cnt_q + TO_W'(1);
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            div_cnt_q  <= '0;
            div_last_q <= '0;
            state_q    <= RX_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            wls_q      <= WLS_8;
            pen_q      <= 1'b0;
            eps_q      <= 1'b0;
            oe_q       <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            bi_q       <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            sync1_q    <= RX_I;
            sync2_q    <= sync1_q;
            rx_prev_q  <= sync2_q;
            div_cnt_q  <= div_cnt_d;
            div_last_q <= DIVISOR_I;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            wls_q      <= wls_d;
            pen_q      <= pen_d;
            eps_q      <= eps_d;
            oe_q       <= oe_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            bi_q       <= bi_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk        (CLK_I),
        .rst        (RST_I),
        .clr_i      (FIFO_CLR_I),
        .push_i     (push_req),
        .data_i     (shift_q),
        .pop_i      (POP_I),
        .data_o     (DATA_O),
        .count_o    (COUNT_O),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_ovf)
    );

    logic unused_full;
    assign unused_full = fifo_full;

    assign VALID_O   = !fifo_empty;
    assign OE_O      = oe_q;
    assign PE_O      = pe_q;
    assign FE_O      = fe_q;
    assign BI_O      = bi_q;
    assign TIMEOUT_O = (to_cnt_q == TO_MAX);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed self-checking bench for uart_rx_deser: frames, parity, overrun,
// break, glitch rejection, config latching, divisor and character timeout.
module tb_uart_rx_deser;

    logic        CLK_I = 1'b0;
    logic        RST_I, RX_I, PEN_I, EPS_I, FIFO_CLR_I, POP_I, ERR_CLR_I;
    logic [15:0] DIVISOR_I;
    logic [1:0]  WLS_I;
    logic [7:0]  DATA_O;
    logic        VALID_O, OE_O, PE_O, FE_O, BI_O, TIMEOUT_O;
    logic [6:0]  COUNT_O;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 CLK_I = ~CLK_I;

    uart_rx_deser #(.FIFO_DEPTH(32), .TIMEOUT_TICKS(640)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .RX_I(RX_I), .DIVISOR_I(DIVISOR_I),
        .WLS_I(WLS_I), .PEN_I(PEN_I), .EPS_I(EPS_I), .FIFO_CLR_I(FIFO_CLR_I),
        .POP_I(POP_I), .ERR_CLR_I(ERR_CLR_I), .DATA_O(DATA_O), .VALID_O(VALID_O),
        .COUNT_O(COUNT_O), .OE_O(OE_O), .PE_O(PE_O), .FE_O(FE_O), .BI_O(BI_O),
        .TIMEOUT_O(TIMEOUT_O)
    );

    task automatic wait_clks(input int n);
        repeat (n) @(negedge CLK_I);
    endtask

    // wls_chg >= 0 changes WLS_I when data bit 2 begins.
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit has_par,
                              input logic par, input logic stop, input int bclk,
                              input int wls_chg);
        RX_I = 1'b0;
        wait_clks(bclk);
        for (int i = 0; i < nbits; i++) begin
            if (i == 2 && wls_chg >= 0) WLS_I = 2'(wls_chg);
            RX_I = d[i];
            wait_clks(bclk);
        end
        if (has_par) begin
            RX_I = par;
            wait_clks(bclk);
        end
        RX_I = stop;
        wait_clks(bclk);
        RX_I = 1'b1;
        wait_clks(4);
    endtask

    task automatic pulse_pop();
        POP_I = 1'b1; wait_clks(1); POP_I = 1'b0; wait_clks(1);
    endtask

    task automatic pulse_err_clr();
        ERR_CLR_I = 1'b1; wait_clks(1); ERR_CLR_I = 1'b0; wait_clks(1);
    endtask

    task automatic pulse_flush();
        FIFO_CLR_I = 1'b1; wait_clks(1); FIFO_CLR_I = 1'b0; wait_clks(1);
    endtask

    task automatic test_reset();
        RST_I = 1'b1; RX_I = 1'b1; DIVISOR_I = 16'd1; WLS_I = 2'b11; PEN_I = 1'b0;
        EPS_I = 1'b0; FIFO_CLR_I = 1'b0; POP_I = 1'b0; ERR_CLR_I = 1'b0;
        wait_clks(3);
        n_checks++; if (DATA_O !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", DATA_O); end
        n_checks++; if (VALID_O !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", VALID_O); end
        n_checks++; if (COUNT_O !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", COUNT_O); end
        n_checks++; if ({OE_O, PE_O, FE_O, BI_O, TIMEOUT_O} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {OE_O, PE_O, FE_O, BI_O, TIMEOUT_O}); end
        RST_I = 1'b0;
        wait_clks(3);
        // Reset in the middle of a frame drops it.
        RX_I = 1'b0; wait_clks(40);
        RST_I = 1'b1; wait_clks(3);
        RX_I = 1'b1; RST_I = 1'b0;
        wait_clks(300);
        n_checks++; if (COUNT_O !== 7'd0) begin n_fail++; $display("FAIL reset_midframe_count: got %0d want 0", COUNT_O); end
        n_checks++; if ({FE_O, BI_O} !== 2'b00) begin n_fail++; $display("FAIL reset_midframe_flags: got %b want 00", {FE_O, BI_O}); end
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 8, 0, 1'b0, 1'b1, 16, -1);
        n_checks++; if (DATA_O !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", DATA_O); end
        n_checks++; if (VALID_O !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", VALID_O); end
        n_checks++; if (COUNT_O !== 7'd1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", COUNT_O); end
        n_checks++; if ({OE_O, PE_O, FE_O, BI_O} !== 4'b0) begin n_fail++; $display("FAIL basic_flags: got %b want 0000", {OE_O, PE_O, FE_O, BI_O}); end
        pulse_pop();
        n_checks++; if ({VALID_O, COUNT_O} !== 8'h00) begin n_fail++; $display("FAIL basic_pop: got valid %b count %0d want 0 0", VALID_O, COUNT_O); end
        // 5-bit word: upper bits of the entry must read zero.
        WLS_I = 2'b00;
        send_frame(8'h35, 5, 0, 1'b0, 1'b1, 16, -1);
        n_checks++; if (DATA_O !== 8'h15) begin n_fail++; $display("FAIL wls5_data: got %h want 15", DATA_O); end
        pulse_pop();
        WLS_I = 2'b11;
        // Stop bit low: framing error, data still delivered.
        send_frame(8'h3C, 8, 0, 1'b0, 1'b0, 16, -1);
        n_checks++; if (DATA_O !== 8'h3C) begin n_fail++; $display("FAIL fe_data: got %h want 3c", DATA_O); end
        n_checks++; if ({FE_O, BI_O} !== 2'b10) begin n_fail++; $display("FAIL fe_flags: got %b want 10", {FE_O, BI_O}); end
        pulse_pop();
        pulse_err_clr();
        n_checks++; if (FE_O !== 1'b0) begin n_fail++; $display("FAIL fe_clear: got %b want 0", FE_O); end
    endtask

    task automatic test_parity();
        logic exp_pe;
`ifdef UART_RX_PARITY_EN
        exp_pe = 1'b1;
`else
        exp_pe = 1'b0;
`endif
        WLS_I = 2'b10; PEN_I = 1'b1; EPS_I = 1'b1;
        send_frame(8'h41, 7, 1, 1'b1, 1'b1, 16, -1);
        n_checks++; if (DATA_O !== 8'h41) begin n_fail++; $display("FAIL parity_data: got %h want 41", DATA_O); end
        n_checks++; if (PE_O !== exp_pe) begin n_fail++; $display("FAIL parity_pe: got %b want %b", PE_O, exp_pe); end
        n_checks++; if (FE_O !== 1'b0) begin n_fail++; $display("FAIL parity_fe: got %b want 0", FE_O); end
        pulse_err_clr();
        n_checks++; if (PE_O !== 1'b0) begin n_fail++; $display("FAIL parity_clear: got %b want 0", PE_O); end
        pulse_pop();
        WLS_I = 2'b11; PEN_I = 1'b0; EPS_I = 1'b0;
    endtask

    task automatic test_config_latch();
        WLS_I = 2'b11;
        send_frame(8'h96, 8, 0, 1'b0, 1'b1, 16, 0);
        n_checks++; if (DATA_O !== 8'h96) begin n_fail++; $display("FAIL latch_data: got %h want 96", DATA_O); end
        n_checks++; if (COUNT_O !== 7'd1) begin n_fail++; $display("FAIL latch_count: got %0d want 1", COUNT_O); end
        pulse_pop();
        WLS_I = 2'b11;
    endtask

    task automatic test_divisor();
        DIVISOR_I = 16'd2;
        wait_clks(4);
        send_frame(8'hC3, 8, 0, 1'b0, 1'b1, 32, -1);
        n_checks++; if (DATA_O !== 8'hC3) begin n_fail++; $display("FAIL div2_data: got %h want c3", DATA_O); end
        pulse_pop();
        DIVISOR_I = 16'd0;
        wait_clks(4);
        send_frame(8'h66, 8, 0, 1'b0, 1'b1, 16, -1);
        n_checks++; if (DATA_O !== 8'h66) begin n_fail++; $display("FAIL div0_data: got %h want 66", DATA_O); end
        pulse_pop();
        DIVISOR_I = 16'd1;
        wait_clks(4);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 33; i++) send_frame(8'(8'h10 + i), 8, 0, 1'b0, 1'b1, 16, -1);
        n_checks++; if (COUNT_O !== 7'd32) begin n_fail++; $display("FAIL ovf_count: got %0d want 32", COUNT_O); end
        n_checks++; if (OE_O !== 1'b1) begin n_fail++; $display("FAIL ovf_oe: got %b want 1", OE_O); end
        n_checks++; if (DATA_O !== 8'h10) begin n_fail++; $display("FAIL ovf_head: got %h want 10", DATA_O); end
        pulse_pop();
        n_checks++; if ({DATA_O, COUNT_O} !== {8'h11, 7'd31}) begin n_fail++; $display("FAIL ovf_pop: got %h/%0d want 11/31", DATA_O, COUNT_O); end
        pulse_flush();
        n_checks++; if ({VALID_O, COUNT_O, DATA_O} !== 16'h0000) begin n_fail++; $display("FAIL flush_empty: got valid %b count %0d data %h want 0 0 00", VALID_O, COUNT_O, DATA_O); end
        n_checks++; if (OE_O !== 1'b1) begin n_fail++; $display("FAIL flush_keeps_oe: got %b want 1", OE_O); end
        pulse_err_clr();
        n_checks++; if (OE_O !== 1'b0) begin n_fail++; $display("FAIL oe_clear: got %b want 0", OE_O); end
    endtask

    task automatic test_break();
        RX_I = 1'b0;
        wait_clks(30 * 16);
        n_checks++; if ({COUNT_O, DATA_O} !== {7'd1, 8'h00}) begin n_fail++; $display("FAIL break_entry: got %0d/%h want 1/00", COUNT_O, DATA_O); end
        n_checks++; if ({BI_O, FE_O} !== 2'b11) begin n_fail++; $display("FAIL break_flags: got %b want 11", {BI_O, FE_O}); end
        RX_I = 1'b1;
        wait_clks(40);
        n_checks++; if (COUNT_O !== 7'd1) begin n_fail++; $display("FAIL break_single: got %0d want 1", COUNT_O); end
        pulse_pop();
        pulse_err_clr();
        n_checks++; if ({BI_O, FE_O} !== 2'b00) begin n_fail++; $display("FAIL break_clear: got %b want 00", {BI_O, FE_O}); end
    endtask

    task automatic test_glitch_timeout();
        RX_I = 1'b0; wait_clks(4); RX_I = 1'b1;
        wait_clks(40);
        n_checks++; if ({VALID_O, COUNT_O} !== 8'h00) begin n_fail++; $display("FAIL glitch_count: got %0d want 0", COUNT_O); end
        send_frame(8'h5A, 8, 0, 1'b0, 1'b1, 16, -1);
        n_checks++; if (DATA_O !== 8'h5A) begin n_fail++; $display("FAIL glitch_next_data: got %h want 5a", DATA_O); end
        n_checks++; if (TIMEOUT_O !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b want 0", TIMEOUT_O); end
        wait_clks(600);
        n_checks++; if (TIMEOUT_O !== 1'b0) begin n_fail++; $display("FAIL timeout_before: got %b want 0", TIMEOUT_O); end
        wait_clks(50);
        n_checks++; if (TIMEOUT_O !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b want 1", TIMEOUT_O); end
        POP_I = 1'b1; wait_clks(1); POP_I = 1'b0;
        n_checks++; if ({TIMEOUT_O, VALID_O} !== 2'b00) begin n_fail++; $display("FAIL timeout_pop: got %b want 00", {TIMEOUT_O, VALID_O}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_config_latch();
        test_divisor();
        test_overflow();
        test_break();
        test_glitch_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
